// File: rtl/toggle_rx_pkg.sv
// Shared definitions for the two-phase toggle receiver: FSM state encoding
// and default data/counter widths.
package toggle_rx_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t BUSY = 1'b1;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

endpackage

// File: rtl/toggle_det.sv
// Two-phase level-change detector: registers the incoming toggle line and
// flags any cycle where the live level differs from the registered one.
module toggle_det (
  input  logic clk,
  input  logic res,
  input  logic t_in,
  output logic evt
);

  logic t_reg;

  // Loads the live level even in reset so a line already high at release
  // is not mistaken for a request.
  always_ff @(posedge clk) begin
    t_reg <= t_in;
  end

  assign evt = t_in ^ t_reg;

endmodule

// File: rtl/toggle_rx.sv
// Two-phase handshake receiver: captures one word per req_t toggle, presents
// it with valid/ready, and acknowledges consumption by toggling ack_t.
module toggle_rx
  import toggle_rx_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic             req_t,
  input  logic [WIDTH-1:0] din,
  input  logic             ready,
  output logic             ack_t,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  output logic             err,
  output logic [CNT_W-1:0] evt_cnt
);

  logic             evt;
  logic             load;
  state_t           state_reg, state_next;
  logic             ack_reg, ack_next;
  logic             err_reg, err_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [WIDTH-1:0] dout_reg;

  toggle_det u_det (
    .clk  (clk),
    .res  (res),
    .t_in (req_t),
    .evt  (evt)
  );

  always_comb begin
    state_next = state_reg;
    ack_next   = ack_reg;
    err_next   = err_reg;
    cnt_next   = cnt_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (evt) begin
          load       = 1'b1;
          cnt_next   = cnt_reg + 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        // A toggle while a word is still held is dropped, not queued.
        if (evt) begin
          err_next = 1'b1;
        end
        if (ready) begin
          ack_next   = ~ack_reg;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!res) begin
      state_reg <= IDLE;
      ack_reg   <= 1'b0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      ack_reg   <= ack_next;
      err_reg   <= err_next;
      cnt_reg   <= cnt_next;
    end
  end

  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_dout
      always_ff @(posedge clk) begin
        if (!res) begin
          dout_reg[gi] <= 1'b0;
        end else if (load) begin
          dout_reg[gi] <= din[gi];
        end
      end
    end
  endgenerate

  assign ack_t   = ack_reg;
  assign dout    = dout_reg;
  assign valid   = (state_reg == BUSY);
  assign err     = err_reg;
  assign evt_cnt = cnt_reg;

endmodule

// File: tb/tb_toggle_rx.sv
// Self-checking bench for toggle_rx: directed scenarios with literal
// expectations, then randomized traffic against a transaction-level model.
module tb_toggle_rx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             res;
  logic             req_t;
  logic [WIDTH-1:0] din;
  logic             ready;
  logic             ack_t;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             err;
  logic [CNT_W-1:0] evt_cnt;

  int checks = 0;
  int passes = 0;

  // Model: words awaiting consumption, running totals of accepts and acks.
  logic [WIDTH-1:0] m_pending[$];
  logic [WIDTH-1:0] m_dout;
  int unsigned      m_accepted;
  int unsigned      m_acks;
  bit               m_err;
  bit               m_prev_req;

  toggle_rx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .res     (res),
    .req_t   (req_t),
    .din     (din),
    .ready   (ready),
    .ack_t   (ack_t),
    .dout    (dout),
    .valid   (valid),
    .err     (err),
    .evt_cnt (evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h", name, got, exp);
  endtask

  task automatic model_edge(input bit r, input bit q, input logic [WIDTH-1:0] d, input bit rd);
    bit toggled;
    if (!r) begin
      m_pending.delete();
      m_dout     = '0;
      m_accepted = 0;
      m_acks     = 0;
      m_err      = 1'b0;
      m_prev_req = q;
    end else begin
      toggled    = (q != m_prev_req);
      m_prev_req = q;
      if (m_pending.size() != 0) begin
        if (toggled) m_err = 1'b1;
        if (rd) begin
          void'(m_pending.pop_front());
          m_acks++;
        end
      end else if (toggled) begin
        m_pending.push_back(d);
        m_dout = d;
        m_accepted++;
      end
    end
  endtask

  // One clock cycle: drive, advance model, clock, then compare every output.
  task automatic step(input bit r, input bit q, input logic [WIDTH-1:0] d, input bit rd);
    logic [CNT_W-1:0] exp_cnt;
    res = r; req_t = q; din = d; ready = rd;
    model_edge(r, q, d, rd);
    @(posedge clk);
    #1;
    exp_cnt = m_accepted[CNT_W-1:0];
    chk("valid",   32'(valid),   32'(m_pending.size() != 0));
    chk("dout",    32'(dout),    32'(m_dout));
    chk("ack_t",   32'(ack_t),   32'(m_acks[0]));
    chk("err",     32'(err),     32'(m_err));
    chk("evt_cnt", 32'(evt_cnt), 32'(exp_cnt));
    $display("t=%0t res=%0b req=%0b din=%02h rdy=%0b -> valid=%0b dout=%02h ack=%0b err=%0b cnt=%0d",
             $time, r, q, d, rd, valid, dout, ack_t, err, evt_cnt);
  endtask

  initial begin
    bit q;
    res = 1'b0; req_t = 1'b0; din = '0; ready = 1'b0;
    m_dout = '0; m_accepted = 0; m_acks = 0; m_err = 1'b0; m_prev_req = 1'b0;
    #1;

    // Reset state
    step(1'b0, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_cnt",   32'(evt_cnt), 32'd0);

    // Single transfer accept, then consume
    step(1'b1, 1'b1, 8'hA5, 1'b0);
    chk("accept_valid", 32'(valid), 32'd1);
    chk("accept_dout",  32'(dout),  32'hA5);
    chk("accept_cnt",   32'(evt_cnt), 32'd1);
    chk("accept_ack",   32'(ack_t), 32'd0);
    step(1'b1, 1'b1, 8'h00, 1'b1);
    chk("consume_valid", 32'(valid), 32'd0);
    chk("consume_ack",   32'(ack_t), 32'd1);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    chk("idle_valid", 32'(valid), 32'd0);

    // Toggle while busy with simultaneous consumption
    step(1'b1, 1'b0, 8'h3C, 1'b0);
    chk("busy2_dout", 32'(dout), 32'h3C);
    step(1'b1, 1'b1, 8'h77, 1'b1);
    chk("viol_ack",   32'(ack_t),   32'd0);
    chk("viol_valid", 32'(valid),   32'd0);
    chk("viol_err",   32'(err),     32'd1);
    chk("viol_cnt",   32'(evt_cnt), 32'd2);
    chk("viol_dout",  32'(dout),    32'h3C);

    // Error does not block; reset while busy discards word
    step(1'b1, 1'b0, 8'h11, 1'b0);
    chk("post_err_valid", 32'(valid), 32'd1);
    chk("post_err_cnt",   32'(evt_cnt), 32'd3);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("rstbusy_valid", 32'(valid), 32'd0);
    chk("rstbusy_dout",  32'(dout),  32'd0);
    chk("rstbusy_ack",   32'(ack_t), 32'd0);
    chk("rstbusy_err",   32'(err),   32'd0);
    chk("rstbusy_cnt",   32'(evt_cnt), 32'd0);

    // req_t held high through reset release
    step(1'b0, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    chk("hold_valid", 32'(valid), 32'd0);
    chk("hold_cnt",   32'(evt_cnt), 32'd0);

    // Sixteen full transfers wrap the 4-bit counter
    q = 1'b1;
    for (int i = 0; i < 16; i++) begin
      q = ~q;
      step(1'b1, q, 8'(i * 17 + 3), 1'b0);
      step(1'b1, q, 8'h00, 1'b1);
    end
    chk("wrap_cnt", 32'(evt_cnt), 32'd0);
    chk("wrap_ack", 32'(ack_t),   32'd0);
    chk("wrap_err", 32'(err),     32'd0);

    // Randomized traffic
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 2) == 0) q = ~q;
      step(($urandom_range(0, 99) != 0), q, 8'($urandom), ($urandom_range(0, 2) != 0));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/toggle_rx.md
TOGGLE_RX -- requirements
Module: toggle_rx

Interface
REQ-001 SHALL have parameter WIDTH, default 8, bit width of the data word.
REQ-002 SHALL have parameter CNT_W, default 16, bit width of the accepted-event counter.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port res  input  1  reset, synchronous and active-low; on a rising clk edge with res=0 all state is reset.
REQ-005 SHALL have port req_t  input  1  two-phase request; every level change is one transfer request from the initiator.
REQ-006 SHALL have port din  input  WIDTH  request data, stable while req_t differs from ack_t.
REQ-007 SHALL have port ready  input  1  consumer accepts dout this cycle when valid=1.
REQ-008 SHALL have port ack_t  output  1  two-phase acknowledge; toggles once per consumed transfer.
REQ-009 SHALL have port dout  output  WIDTH  captured data word.
REQ-010 SHALL have port valid  output  1  dout holds an unconsumed word.
REQ-011 SHALL have port err  output  1  sticky protocol-violation flag.
REQ-012 SHALL have port evt_cnt  output  CNT_W  count of accepted transfers.

Function
REQ-013 SHALL keep an internal register req_q that samples req_t on every clk edge.
REQ-014 SHALL define a toggle event in a cycle as req_t != req_q.
REQ-015 SHALL implement a two-state FSM: IDLE (valid=0) and BUSY (valid=1).
REQ-016 In IDLE with a toggle event, SHALL on that edge load dout<=din, set valid=1, increment evt_cnt and enter BUSY; latency is one edge from the req_t change to valid=1.
REQ-017 In IDLE without a toggle event, SHALL hold all outputs.
REQ-018 In BUSY with ready=1, SHALL on that edge clear valid, toggle ack_t and return to IDLE.
REQ-019 In BUSY with ready=0, SHALL hold dout, valid and ack_t unchanged.
REQ-020 In BUSY, a toggle event SHALL set err=1, leave dout and evt_cnt unchanged and drop the request; this also applies when ready=1 in the same cycle, where consumption per REQ-018 still occurs.
REQ-021 ready while in IDLE SHALL have no effect.
REQ-022 evt_cnt SHALL wrap from 2^CNT_W-1 to 0 without setting err.
REQ-023 err SHALL stay set until reset; it SHALL NOT block further transfers.
REQ-024 ack_t SHALL change only on consumption, never on a toggle event alone.

Reset
REQ-025 With res=0 at a clk edge, SHALL set ack_t=0, valid=0, dout=0, err=0, evt_cnt=0 and FSM=IDLE.
REQ-026 During reset, req_q SHALL load req_t, so a req_t already high at reset release produces no event.
REQ-027 Reset asserted while BUSY SHALL discard the held word; ack_t does not toggle.

Structure
REQ-028 Package toggle_rx_pkg SHALL hold the FSM state type (IDLE, BUSY) and the default WIDTH and CNT_W constants.
REQ-029 The req_q register and event detection SHALL live in sub-module toggle_det (ports clk, res, t_in, evt), reused by later two-phase blocks.

Verification
REQ-030 Reset, then req_t 0->1 with din=8'hA5 and ready=0: one edge later valid=1, dout=A5, evt_cnt=1, ack_t=0.
REQ-031 From REQ-030, raise ready for one cycle: on that edge valid=0, ack_t=1, and valid stays 0 with no further toggles.
REQ-032 Hold req_t=1 through reset release: no event, valid=0, evt_cnt=0.
REQ-033 While BUSY, toggle req_t with ready=1 in the same cycle: ack_t toggles, valid=0, err=1, evt_cnt unchanged.
REQ-034 With CNT_W=4, run 16 complete transfers: evt_cnt returns to 0, ack_t=0, err=0.
REQ-035 Assert res=0 while BUSY: next edge valid=0, dout=0, ack_t=0, err=0, evt_cnt=0.
